// File: rtl/mem_wb_stage.sv
// Memory + writeback stage: runs loads/stores on a req/gnt/rvalid bus, stalls while a
// transaction is outstanding, and registers the M->W boundary. Define SUBWORD_ACCESS_EN for byte/half accesses.
module mem_wb_stage #(
    parameter int TIMEOUT = 255,
    parameter int TCW     = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] alu_resultM,
    input  logic [31:0] write_dataM,
    input  logic [4:0]  RdM,
    input  logic [31:0] PC_plus4M,
    input  logic        reg_writeM,
    input  logic        mem_readM,
    input  logic        mem_writeM,
    input  logic [1:0]  result_srcM,
    input  logic [2:0]  funct3M,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        stallM,
    output logic [31:0] resultW,
    output logic [4:0]  RdW,
    output logic        reg_writeW,
    output logic        bus_errW
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t         state;
    logic [TCW-1:0] cnt;
    logic           memop;
    logic [1:0]     addr_lo;
    logic           misalign;
    logic           timeout;
    logic           done;
    logic [31:0]    load_data;
    logic [31:0]    result_next;

    assign memop     = mem_readM | mem_writeM;
    assign addr_lo   = alu_resultM[1:0];
    assign dmem_we   = mem_writeM;
    assign dmem_addr = {alu_resultM[31:2], 2'b00};

`ifdef SUBWORD_ACCESS_EN
    logic [31:0] rdata_shift;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        rdata_shift = dmem_rdata >> {addr_lo, 3'b000};
        case (funct3M)
            3'b000:  load_data = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
            3'b001:  load_data = {{16{rdata_shift[15]}}, rdata_shift[15:0]};
            3'b100:  load_data = {24'd0, rdata_shift[7:0]};
            3'b101:  load_data = {16'd0, rdata_shift[15:0]};
            default: load_data = dmem_rdata;
        endcase

        // funct3[1:0]: 00 byte (never misaligned), 01 half, 1x word
        misalign = memop & (((funct3M[1:0] == 2'b01) & addr_lo[0]) |
                            (funct3M[1] & (addr_lo != 2'b00)));

        dmem_wdata = write_dataM;
        dmem_be    = 4'b1111;
        if (mem_writeM) begin
            case (funct3M[1:0])
                2'b00: begin
                    dmem_wdata = {4{write_dataM[7:0]}};
                    dmem_be    = 4'b0001 << addr_lo;
                end
                2'b01: begin
                    dmem_wdata = {2{write_dataM[15:0]}};
                    dmem_be    = 4'b0011 << addr_lo;
                end
                default: begin
                    dmem_wdata = write_dataM;
                    dmem_be    = 4'b1111;
                end
            endcase
        end
    end
`else
    logic unused_funct3;

    assign unused_funct3 = ^funct3M;
    assign load_data     = dmem_rdata;
    assign misalign      = memop & (addr_lo != 2'b00);
    assign dmem_wdata    = write_dataM;
    assign dmem_be       = 4'b1111;
`endif

    assign timeout  = (state != IDLE) && (cnt == TCW'(TIMEOUT));
    assign dmem_req = memop & ~misalign & ((state == IDLE) | (state == REQ));
    assign done     = misalign | timeout |
                      (mem_writeM & dmem_req & dmem_gnt) |
                      (mem_readM & (state == RESP) & dmem_rvalid);
    assign stallM   = memop & ~done;

    // Errored loads (misalign or timeout) write zero rather than whatever is on the bus.
    always_comb begin
        case (result_srcM)
            2'b01:   result_next = (misalign | timeout) ? 32'd0 : load_data;
            2'b10:   result_next = PC_plus4M;
            default: result_next = alu_resultM;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            if (state == IDLE || done) cnt <= '0;
            else                       cnt <= cnt + 1'b1;

            case (state)
                IDLE: begin
                    if (memop && !misalign) begin
                        if (!dmem_gnt)      state <= REQ;
                        else if (mem_readM) state <= RESP;
                    end
                end
                REQ: begin
                    if (timeout)       state <= IDLE;
                    else if (dmem_gnt) state <= mem_readM ? RESP : IDLE;
                end
                RESP: begin
                    if (timeout || dmem_rvalid) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A stall cycle inserts a bubble; destination and value hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resultW    <= '0;
            RdW        <= '0;
            reg_writeW <= 1'b0;
            bus_errW   <= 1'b0;
        end else begin
            bus_errW <= bus_errW | misalign | timeout;
            if (stallM) begin
                reg_writeW <= 1'b0;
            end else begin
                resultW    <= result_next;
                RdW        <= RdM;
                reg_writeW <= reg_writeM;
            end
        end
    end

endmodule
